// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between the register bank (master) and the divider (slave).
interface clk_div_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider; new divisors take effect only at a period boundary
// so clk_out never shows a runt pulse.
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  clk_div_ctrl_if.slave       cfg,
  output logic [WIDTH-1:0]    div_cur,
  output logic                clk_out,
  output logic                tick,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StRun, StPend, StStop} state_e;

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             div_ok;
  logic             at_end;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] low_len;

  assign cfg.cfg_ready = (state_q != StPend);
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign div_ok        = (cfg.cfg_div >= WIDTH'(2));
  assign at_end        = (cnt_q == div_q - WIDTH'(1));
  assign cnt_inc       = at_end ? '0 : cnt_q + WIDTH'(1);
  // Ceiling of N/2: odd divisors keep the longer phase low.
  assign low_len       = div_q - (div_q >> 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    div_d    = div_q;
    shadow_d = shadow_q;
    err_d    = xfer && !div_ok;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (xfer && div_ok) div_d = cfg.cfg_div;
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (xfer && div_ok) begin
          shadow_d = cfg.cfg_div;
          state_d  = StPend;
        end else if (!enable) begin
          state_d = at_end ? StIdle : StStop;
        end
      end
      StStop: begin
        // A divisor offered while winding down is held like one offered while running.
        if (xfer && div_ok) begin
          shadow_d = cfg.cfg_div;
          state_d  = StPend;
        end else if (enable) begin
          state_d = StRun;
        end else if (at_end) begin
          state_d = StIdle;
        end
      end
      StPend: begin
        if (at_end) begin
          div_d   = shadow_q;
          state_d = enable ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end else begin
      clk_out_d = (cnt_d >= low_len);
      tick_d    = (cnt_d == low_len);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DefDiv;
      shadow_q  <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign cfg.cfg_err = err_q;
  assign div_cur     = div_q;
  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position reference model queues the expected
// outputs for every clock, and a negedge monitor compares them against the DUT.
module tb_clk_div_ctrl;
  localparam int unsigned W   = 8;
  localparam int unsigned DEF = 2;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] div_cur;
  logic         clk_out;
  logic         tick;
  logic         busy;

  clk_div_ctrl_if #(.WIDTH(W)) cfg_if ();

  clk_div_ctrl #(
    .WIDTH      (W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .cfg    (cfg_if),
    .div_cur(div_cur),
    .clk_out(clk_out),
    .tick   (tick),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic         clk_o;
    logic         tick_o;
    logic         busy_o;
    logic         ready_o;
    logic         err_o;
    logic [W-1:0] div_o;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: whether a period is in progress, position within it, period length,
  // and an optional divisor waiting for the next boundary.
  bit m_active, m_pend, m_err;
  int m_pos, m_n, m_shadow;

  task automatic model_reset();
    m_active = 0;
    m_pend   = 0;
    m_err    = 0;
    m_pos    = 0;
    m_n      = DEF;
    m_shadow = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int d);
    bit xfer, last;
    xfer  = v && !m_pend;
    m_err = xfer && (d < 2);
    if (!m_active) begin
      if (xfer && d >= 2) m_n = d;
      if (en) begin
        m_active = 1;
        m_pos    = 0;
      end
    end else begin
      last = (m_pos == m_n - 1);
      if (m_pend) begin
        if (last) begin
          m_n      = m_shadow;
          m_pend   = 0;
          m_active = en;
        end
      end else if (xfer && d >= 2) begin
        m_shadow = d;
        m_pend   = 1;
      end else if (!en && last) begin
        m_active = 0;
      end
      m_pos = last ? 0 : m_pos + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   half;
    half     = (m_n + 1) / 2;
    e.clk_o  = m_active && (m_pos >= half);
    e.tick_o = m_active && (m_pos == half);
    e.busy_o = m_active;
    e.ready_o = !m_pend;
    e.err_o  = m_err;
    e.div_o  = W'(m_n);
    return e;
  endfunction

  // One clock: apply the model to the inputs sampled at this edge, queue the expectation,
  // then drive the inputs for the next edge.
  task automatic cycle(input bit en_n, input bit v_n, input int d_n, input bit fire_rst);
    @(posedge clk_in);
    #1;
    if (reset) model_reset();
    else       model_step(enable, cfg_if.cfg_valid, int'(cfg_if.cfg_div));
    if (fire_rst) begin
      reset = 1'b1;
      model_reset();
    end else begin
      reset = 1'b0;
    end
    sb.push_back(model_out());
    enable           = en_n;
    cfg_if.cfg_valid = v_n;
    cfg_if.cfg_div   = W'(d_n);
  endtask

  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk_in);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {clk_out, tick, busy, cfg_if.cfg_ready, cfg_if.cfg_err, div_cur};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL cycle %0d at %0t: got clk_out=%b tick=%b busy=%b ready=%b err=%b div=%0d, want clk_out=%b tick=%b busy=%b ready=%b err=%b div=%0d",
                   vectors, $time, g.clk_o, g.tick_o, g.busy_o, g.ready_o, g.err_o, g.div_o,
                   e.clk_o, e.tick_o, e.busy_o, e.ready_o, e.err_o, e.div_o);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    bit en, v, r;
    int d;
    model_reset();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;

    cycle(0, 0, 0, 0);
    // Default divisor of 2
    repeat (8) cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    // Load 5 while idle, then run
    cycle(0, 1, 5, 0);
    repeat (12) cycle(1, 0, 0, 0);
    // Switch to 4, then offer 6 mid-period
    cycle(1, 1, 4, 0);
    repeat (14) cycle(1, 0, 0, 0);
    cycle(1, 1, 6, 0);
    repeat (16) cycle(1, 0, 0, 0);
    // Rejected divisors
    cycle(1, 1, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    repeat (10) cycle(1, 0, 0, 0);
    // Divisor 8, drop enable partway through a period
    cycle(1, 1, 8, 0);
    repeat (19) cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    // Simultaneous enable and divisor in idle
    cycle(1, 1, 3, 0);
    repeat (9) cycle(1, 0, 0, 0);
    // Reset while a long divisor is pending
    cycle(1, 1, 200, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    repeat (12) cycle(1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 19) == 0);
      d  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 9));
      r  = ($urandom_range(0, 499) == 0);
      cycle(en, v, d, r);
    end

    repeat (3) cycle(0, 0, 0, 0);
    @(negedge clk_in);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time programmable clock-divider controller. It generates a divided clock `clk_out` from `clk_in` and accepts new divisor values over a valid/ready handshake. New divisors are applied only at a period boundary, so `clk_out` never shows a truncated or runt pulse. It sits between the configuration register bank and every consumer of a derived slow clock or clock-enable, and replaces fixed-divisor dividers where the rate must change in the field.

## Interface
Parameters:
- `WIDTH`, 8, width of the divisor and of the internal counter.
- `DEFAULT_DIV`, 2, divisor loaded at reset; must be at least 2.

Ports:
- `clk_in`  input  1  single clock for the whole block.
- `reset`  input  1  asynchronous, active-high reset.
- `enable`  input  1  level; run the divider while high.
- `cfg_valid`  input  1  a new divisor is offered.
- `cfg_div`  input  WIDTH  offered divisor N.
- `cfg_ready`  output  1  a divisor can be accepted this cycle.
- `cfg_err`  output  1  one-cycle pulse when the offered divisor is rejected.
- `div_cur`  output  WIDTH  divisor currently in effect.
- `clk_out`  output  1  registered divided clock.
- `tick`  output  1  one-cycle pulse coinciding with each `clk_out` rising edge.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Internal state: counter `cnt` [WIDTH-1:0] and FSM states IDLE, RUN, PEND, STOP.
- Low-phase length L = N - N/2 (ceiling of N/2). High-phase length is N/2 (integer division). One period is exactly N cycles.
- While running, `cnt` counts 0..N-1 and wraps to 0.
  - `clk_out` is 1 iff `cnt` ≥ L.
  - `tick` is 1 iff `cnt` == L.
  - Both are registered and change on the same edge as `cnt`.
  - Odd N gives the longer phase low (N=3 → 0,0,1).
- Handshake:
  - `cfg_ready` = (state != PEND); it is combinational from state.
  - A transfer happens on a `clk_in` edge where `cfg_valid` and `cfg_ready` are both high.
- Accept rules:
  - `cfg_div` < 2: the transfer completes, `cfg_err` pulses for 1 cycle, `div_cur` is unchanged and the state is unchanged.
  - Valid divisor in IDLE: `div_cur` takes the new value on the accepting edge.
  - Valid divisor in RUN: held in a shadow register; go to PEND.
- FSM transitions:
  - IDLE → RUN when `enable` = 1. `cnt` = 0 and `clk_out` = 0 on that edge.
  - RUN → STOP when `enable` = 0 and `cnt` != N-1.
  - RUN → IDLE when `enable` = 0 and `cnt` == N-1.
  - RUN → PEND on an accepted valid divisor.
  - PEND → RUN at `cnt` == N-1: `div_cur` takes the shadow value and `cnt` wraps to 0, so the new period starts immediately. If `enable` = 0 at that edge, go to IDLE instead, still committing the shadow value.
  - PEND with `enable` = 0 before the boundary: stay in PEND until `cnt` == N-1, then commit the shadow value and go to IDLE.
  - STOP → IDLE at `cnt` == N-1, i.e. the current period always completes.
  - STOP → RUN if `enable` returns to 1 before the boundary; counting is uninterrupted.
- In IDLE: `cnt` = 0, `clk_out` = 0, `tick` = 0.
- `busy` = (state != IDLE).

## Timing
- Reset values (asynchronous): state IDLE, `cnt` 0, `div_cur` = DEFAULT_DIV, `clk_out` 0, `tick` 0, `cfg_err` 0, `cfg_ready` 1, `busy` 0.
- Startup latency: `enable` sampled high on edge k gives the first `clk_out` rise and `tick` on edge k+L.
- Divisor change latency: the new N takes effect on the first period boundary strictly after the accepting edge.
  - A transfer accepted on the boundary edge itself (`cnt` == N-1) is applied at the next boundary, N cycles later.
- Simultaneous `enable` rise and valid transfer in IDLE: the run starts with the new N.
- A rejected transfer (`cfg_err`) never affects `clk_out`, `cnt` or the state.
- Reset asserted mid-period: all outputs return to reset values immediately and any pending shadow divisor is discarded.
- Counter width: WIDTH bits; N up to 2^WIDTH-1 is legal. No arithmetic overflow because `cnt` ≤ N-1.

## Test plan
- Reset, then `enable` = 1 with DEFAULT_DIV = 2 → `clk_out` toggles 0,1,0,1 from edge k+1; `tick` every 2 cycles; `busy` = 1.
- Load N = 5 in IDLE, then enable → `clk_out` pattern 0,0,0,1,1 repeating; `tick` at `cnt` = 3; `div_cur` = 5.
- In RUN with N = 4, offer N = 6 at `cnt` = 1 → `cfg_ready` drops the next cycle; the current period completes as 4 cycles; the next period is 6 cycles (0,0,0,1,1,1); `cfg_ready` returns to 1.
- Offer N = 1 and N = 0 → `cfg_err` pulses 1 cycle each; `div_cur` and the `clk_out` period are unchanged.
- With N = 8, drop `enable` at `cnt` = 2 → `clk_out` completes its high phase; IDLE is entered after `cnt` = 7; `busy` falls; `clk_out` = 0.
- Assert `reset` while in PEND → `div_cur` = DEFAULT_DIV, `clk_out` = 0, `cfg_ready` = 1; the shadow value is never applied.
